// File: rtl/msd_fe_adc_emulator.sv
// msd_fe_adc_emulator: emulates the microstrip FE daisy chain plus its serial
// ADCs so the MSD interface can be exercised in loopback without detectors.
//
// Ports:
//   iCLK, iRSTn         fast system clock, asynchronous active-low reset
//   iFE_HOLD            rising edge arms an event, falling edge while active aborts it
//   iFE_SHIFT           shift-in token, sampled on the iFE_CLK rising edge
//   iFE_CLK             FE readout clock, each rising edge advances the channel
//   iADC_CS             ADC chip select (active low), falling edge starts a conversion
//   iADC_SCLK           ADC serial clock, data advances on its falling edge
//   oADC_SDATA[N_ADC]   one MSB-first serial data line per ADC
//   oBUSY               event armed or active
//   oEVT_CNT            completed events, wraps
//   oERR                sticky protocol error, cleared only by reset
//
// Build option: define MSD_EMU_PRBS_EN to replace the ramp samples with a
// per-ADC 12-bit LFSR sequence.
module msd_fe_adc_emulator #(
  parameter int unsigned ADC_DATA_WIDTH = 12,
  parameter int unsigned ADC_FRAME_BITS = 16,
  parameter int unsigned FE_CHANNELS    = 64,
  parameter int unsigned FE_DAISY_DEPTH = 10,
  parameter int unsigned N_ADC          = 10,
  parameter int unsigned ADC_STEP       = 37
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic             iFE_HOLD,
  input  logic             iFE_SHIFT,
  input  logic             iFE_CLK,
  input  logic             iADC_CS,
  input  logic             iADC_SCLK,
  output logic [N_ADC-1:0] oADC_SDATA,
  output logic             oBUSY,
  output logic [15:0]      oEVT_CNT,
  output logic             oERR
);

  localparam int unsigned CH_TOTAL = FE_CHANNELS * FE_DAISY_DEPTH;
  localparam int unsigned CH_W     = $clog2(CH_TOTAL + 1);
  localparam int unsigned BIT_W    = $clog2(ADC_FRAME_BITS + 1);

  // Bit positions inside the edge-detected synchronizer vector
  localparam int unsigned I_HOLD   = 0;
  localparam int unsigned I_FE_CLK = 1;
  localparam int unsigned I_CS     = 2;
  localparam int unsigned I_SCLK   = 3;
  // CS resets to its idle (high) level so reset release creates no false edge
  localparam logic [3:0]  SYNC_RST = 4'b0100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0] sync1_q, sync2_q, sync3_q;
  logic       shift1_q, shift2_q;

  logic [CH_W-1:0]  ch_q;
  logic [CH_W-1:0]  conv_q;
  logic             frame_on_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [N_ADC-1:0][ADC_FRAME_BITS-1:0] shreg_q;
  logic [N_ADC-1:0][ADC_DATA_WIDTH-1:0] sample_c;

  logic hold_rise_c, hold_fall_c, fe_rise_c, cs_fall_c, cs_rise_c, sclk_fall_c;
  logic start_c, done_c, abort_c;
  logic ch_ovf_c, extra_sclk_c, idle_cs_c, err_set_c;

  // Two-flop synchronizers plus one edge-detect stage
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      sync1_q  <= SYNC_RST;
      sync2_q  <= SYNC_RST;
      sync3_q  <= SYNC_RST;
      shift1_q <= 1'b0;
      shift2_q <= 1'b0;
    end else begin
      sync1_q  <= {iADC_SCLK, iADC_CS, iFE_CLK, iFE_HOLD};
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      shift1_q <= iFE_SHIFT;
      shift2_q <= shift1_q;
    end
  end

  assign hold_rise_c =  sync2_q[I_HOLD]   & ~sync3_q[I_HOLD];
  assign hold_fall_c = ~sync2_q[I_HOLD]   &  sync3_q[I_HOLD];
  assign fe_rise_c   =  sync2_q[I_FE_CLK] & ~sync3_q[I_FE_CLK];
  assign cs_fall_c   = ~sync2_q[I_CS]     &  sync3_q[I_CS];
  assign cs_rise_c   =  sync2_q[I_CS]     & ~sync3_q[I_CS];
  assign sclk_fall_c = ~sync2_q[I_SCLK]   &  sync3_q[I_SCLK];

  // Event FSM state register
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Event FSM next state; abort wins over completion
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    done_c  = 1'b0;
    abort_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_rise_c) state_d = ARMED;
      end
      ARMED: begin
        if (fe_rise_c && shift2_q) begin
          state_d = ACTIVE;
          start_c = 1'b1;
        end
      end
      ACTIVE: begin
        if (hold_fall_c) begin
          state_d = IDLE;
          abort_c = 1'b1;
        end else if (cs_rise_c && frame_on_q && (conv_q == CH_W'(CH_TOTAL - 1))) begin
          state_d = IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Protocol error sources; CS edges take priority over an SCLK edge in the same cycle
  assign ch_ovf_c     = (state_q == ACTIVE) & fe_rise_c & (ch_q == CH_W'(CH_TOTAL - 1));
  assign extra_sclk_c = sclk_fall_c & frame_on_q & ~cs_fall_c & ~cs_rise_c &
                        (bit_cnt_q >= BIT_W'(ADC_FRAME_BITS - 1));
  assign idle_cs_c    = cs_fall_c & (state_q != ACTIVE);
  assign err_set_c    = ch_ovf_c | extra_sclk_c | idle_cs_c | abort_c;

`ifdef MSD_EMU_PRBS_EN
  logic [N_ADC-1:0][11:0] lfsr_q;

  // Fibonacci LFSR x^12+x^6+x^4+x+1, one step per conversion in an active event
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      for (int unsigned a = 0; a < N_ADC; a++) lfsr_q[a] <= 12'(a + 1);
    end else if (cs_fall_c && (state_q == ACTIVE)) begin
      for (int unsigned a = 0; a < N_ADC; a++)
        lfsr_q[a] <= {lfsr_q[a][10:0],
                      lfsr_q[a][11] ^ lfsr_q[a][5] ^ lfsr_q[a][3] ^ lfsr_q[a][0]};
    end
  end

  always_comb begin
    for (int unsigned a = 0; a < N_ADC; a++) sample_c[a] = ADC_DATA_WIDTH'(lfsr_q[a]);
  end
`else
  // Ramp: channel + per-ADC offset + low byte of the event count
  always_comb begin
    for (int unsigned a = 0; a < N_ADC; a++)
      sample_c[a] = ADC_DATA_WIDTH'(32'(ch_q) + a * ADC_STEP + 32'(oEVT_CNT[7:0]));
  end
`endif

  // Channel/conversion counters, event count, status and ADC shift registers
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      ch_q       <= '0;
      conv_q     <= '0;
      oEVT_CNT   <= '0;
      oBUSY      <= 1'b0;
      oERR       <= 1'b0;
      frame_on_q <= 1'b0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
    end else begin
      oBUSY <= (state_d != IDLE);
      if (err_set_c) oERR <= 1'b1;
      if (done_c) oEVT_CNT <= oEVT_CNT + 16'd1;

      if (start_c) begin
        ch_q   <= '0;
        conv_q <= '0;
      end else if (state_q == ACTIVE) begin
        if (fe_rise_c && (ch_q != CH_W'(CH_TOTAL - 1))) ch_q <= ch_q + CH_W'(1);
        if (cs_rise_c && frame_on_q) conv_q <= conv_q + CH_W'(1);
      end

      // Load samples with the pre-increment channel when FE_CLK and CS coincide
      if (cs_fall_c) begin
        frame_on_q <= 1'b1;
        bit_cnt_q  <= '0;
        for (int unsigned a = 0; a < N_ADC; a++)
          shreg_q[a] <= (state_q == ACTIVE) ? ADC_FRAME_BITS'(sample_c[a]) : '0;
      end else if (cs_rise_c) begin
        frame_on_q <= 1'b0;
        bit_cnt_q  <= '0;
        shreg_q    <= '0;
      end else if (sclk_fall_c && frame_on_q) begin
        for (int unsigned a = 0; a < N_ADC; a++) shreg_q[a] <= shreg_q[a] << 1;
        if (bit_cnt_q != BIT_W'(ADC_FRAME_BITS)) bit_cnt_q <= bit_cnt_q + BIT_W'(1);
      end
    end
  end

  always_comb begin
    for (int unsigned a = 0; a < N_ADC; a++) oADC_SDATA[a] = shreg_q[a][ADC_FRAME_BITS-1];
  end

endmodule

// File: tb/tb_msd_fe_adc_emulator.sv
// tb_msd_fe_adc_emulator: drives FE and ADC protocol sequences into the
// emulator; a monitor reassembles serial frames and checks them against a
// queue of expected frames filled by the stimulus process.
module tb_msd_fe_adc_emulator;

  localparam int N_ADC = 10;
  localparam int PH    = 4;

  logic             iCLK;
  logic             iRSTn;
  logic             iFE_HOLD;
  logic             iFE_SHIFT;
  logic             iFE_CLK;
  logic             iADC_CS;
  logic             iADC_SCLK;
  logic [N_ADC-1:0] oADC_SDATA;
  logic             oBUSY;
  logic [15:0]      oEVT_CNT;
  logic             oERR;

  msd_fe_adc_emulator dut (
    .iCLK       (iCLK),
    .iRSTn      (iRSTn),
    .iFE_HOLD   (iFE_HOLD),
    .iFE_SHIFT  (iFE_SHIFT),
    .iFE_CLK    (iFE_CLK),
    .iADC_CS    (iADC_CS),
    .iADC_SCLK  (iADC_SCLK),
    .oADC_SDATA (oADC_SDATA),
    .oBUSY      (oBUSY),
    .oEVT_CNT   (oEVT_CNT),
    .oERR       (oERR)
  );

  typedef struct {
    int nbits;
    int base;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] cap [N_ADC];
  int          cap_n = 0;

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Expected frame per ADC: 4 zeros, 12-bit sample (base + 37*a), zeros beyond 16 bits
  task automatic check_frame();
    exp_t        e;
    logic [15:0] f;
    logic [31:0] w;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_frame: captured %0d bits, required no frame", cap_n);
      return;
    end
    e = sb_q.pop_front();
    if (cap_n != e.nbits) begin
      fails++;
      $display("FAIL frame_len base %0d: got %0d bits, required %0d", e.base, cap_n, e.nbits);
    end
    for (int a = 0; a < N_ADC; a++) begin
      f = 16'((e.base + 37 * a) % 4096);
      w = '0;
      for (int j = 0; j < e.nbits; j++) w = {w[30:0], (j < 16) ? f[15-j] : 1'b0};
      tests++;
      if (cap[a] !== w) begin
        fails++;
        $display("FAIL frame_adc%0d base %0d: got %h, required %h", a, e.base, cap[a], w);
      end
    end
  endtask

  // Monitor: one bit per SCLK rising edge while CS is low, frame closes on CS rise
  initial begin
    for (int a = 0; a < N_ADC; a++) cap[a] = '0;
    forever begin
      @(posedge iADC_SCLK or posedge iADC_CS or negedge iRSTn);
      if (iRSTn !== 1'b1) begin
        cap_n = 0;
        for (int a = 0; a < N_ADC; a++) cap[a] = '0;
      end else if (iADC_CS) begin
        if (cap_n > 0) check_frame();
        cap_n = 0;
        for (int a = 0; a < N_ADC; a++) cap[a] = '0;
      end else begin
        for (int a = 0; a < N_ADC; a++) cap[a] = {cap[a][30:0], oADC_SDATA[a]};
        cap_n++;
      end
    end
  end

  task automatic fe_edge();
    iFE_CLK = 1'b1; cyc(PH);
    iFE_CLK = 1'b0; cyc(PH);
  endtask

  task automatic start_event();
    iFE_HOLD = 1'b1; iFE_SHIFT = 1'b1; cyc(PH);
    iFE_CLK = 1'b1; cyc(PH);
    iFE_CLK = 1'b0; iFE_SHIFT = 1'b0; cyc(PH);
  endtask

  // One conversion; n_rise SCLK rising edges (n_rise-1 falling) are read back
  task automatic conv(input int n_rise, input int base, input bit with_fe);
    exp_t e;
    if (n_rise > 0) begin
      e.nbits = n_rise;
      e.base  = base;
      sb_q.push_back(e);
    end
    iADC_CS = 1'b0;
    if (with_fe) iFE_CLK = 1'b1;
    cyc(PH);
    for (int i = 0; i < n_rise; i++) begin
      iADC_SCLK = 1'b1; cyc(PH);
      if (i < n_rise - 1) begin
        iADC_SCLK = 1'b0; cyc(PH);
      end
    end
    iADC_CS = 1'b1; cyc(PH);
    iADC_SCLK = 1'b0; iFE_CLK = 1'b0; cyc(PH);
  endtask

  initial begin
    iRSTn = 1'b0; iFE_HOLD = 1'b0; iFE_SHIFT = 1'b0; iFE_CLK = 1'b0;
    iADC_CS = 1'b1; iADC_SCLK = 1'b0;
    cyc(3);
    chk("rst_sdata", 32'(oADC_SDATA), 32'd0);
    chk("rst_busy", 32'(oBUSY), 32'd0);
    chk("rst_evt", 32'(oEVT_CNT), 32'd0);
    chk("rst_err", 32'(oERR), 32'd0);
    iRSTn = 1'b1; cyc(PH);

    // Event 1: full 640-channel readout, first and last frames read
    start_event();
    chk("ev1_busy_start", 32'(oBUSY), 32'd1);
    conv(16, 0, 1'b0);
    chk("ev1_busy_frame", 32'(oBUSY), 32'd1);
    chk("ev1_err_frame", 32'(oERR), 32'd0);
    for (int k = 1; k < 640; k++) begin
      fe_edge();
      conv((k == 639) ? 16 : 0, k, 1'b0);
    end
    chk("ev1_evt_cnt", 32'(oEVT_CNT), 32'd1);
    chk("ev1_busy_end", 32'(oBUSY), 32'd0);
    chk("ev1_err_end", 32'(oERR), 32'd0);
    iFE_HOLD = 1'b0; cyc(PH);

    // Event 2: ramp offset by event count, then reset mid-frame on the last channel
    start_event();
    conv(16, 1, 1'b0);
    for (int k = 1; k < 639; k++) begin
      fe_edge();
      conv(0, k + 1, 1'b0);
    end
    fe_edge();
    iADC_CS = 1'b0; cyc(PH);
    for (int i = 0; i < 7; i++) begin
      iADC_SCLK = 1'b1; cyc(PH);
      if (i < 6) begin
        iADC_SCLK = 1'b0; cyc(PH);
      end
    end
    // bit 7 of the frame is sample bit 9; samples 640..973 all have it set
    chk("pre_rst_bit7", 32'(oADC_SDATA), 32'h3FF);
    iRSTn = 1'b0;
    #1;
    chk("midrst_sdata", 32'(oADC_SDATA), 32'd0);
    chk("midrst_busy", 32'(oBUSY), 32'd0);
    chk("midrst_evt", 32'(oEVT_CNT), 32'd0);
    chk("midrst_err", 32'(oERR), 32'd0);
    cyc(2);
    iADC_CS = 1'b1; iADC_SCLK = 1'b0; iFE_HOLD = 1'b0;
    cyc(2);
    iRSTn = 1'b1; cyc(PH);

    // Event A: restarts from channel 0, aborted by hold fall after conversion 100
    start_event();
    conv(16, 0, 1'b0);
    for (int k = 1; k < 100; k++) begin
      fe_edge();
      conv(0, k, 1'b0);
    end
    chk("abort_err_before", 32'(oERR), 32'd0);
    chk("abort_busy_before", 32'(oBUSY), 32'd1);
    iFE_HOLD = 1'b0; cyc(PH);
    chk("abort_busy", 32'(oBUSY), 32'd0);
    chk("abort_evt", 32'(oEVT_CNT), 32'd0);
    chk("abort_err", 32'(oERR), 32'd1);

    iRSTn = 1'b0; cyc(2);
    chk("rst_clears_err", 32'(oERR), 32'd0);
    iRSTn = 1'b1; cyc(PH);

    // Event B: FE_CLK coincident with CS fall, then an overlong frame
    start_event();
    conv(16, 0, 1'b0);
    conv(16, 0, 1'b1);
    chk("coincident_err", 32'(oERR), 32'd0);
    conv(17, 1, 1'b0);
    chk("overlong_err", 32'(oERR), 32'd1);
    chk("overlong_busy", 32'(oBUSY), 32'd1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
